warp_pc_unit: RTL

Parametrised multi-warp program-counter block for the SM core scheduler, replacing the single-context PC register. It holds one PC per warp. Each warp also has a private return-address stack, so the unit supports increment, absolute jump, call and return. Each warp has a sticky fault flag for stack overflow and underflow. The instruction fetch address for the warp selected each cycle is driven on `AR`.

---
 rtl/warp_pc_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/warp_pc_unit.sv
// Multi-warp program-counter unit: one PC, one private return-address stack
// and one sticky fault flag per warp. The warp addressed by warp_sel gets this
// cycle's command; AR and depth read that warp's state combinationally.
module warp_pc_unit #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    NUM_WARPS   = 4,
    parameter int                    STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    localparam int SEL_W   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SEL_W-1:0]      warp_sel,
    input  logic                  incPC,
    input  logic                  loadFromI,
    input  logic                  call,
    input  logic                  ret,
    input  logic [ADDR_WIDTH-1:0] I,
    output logic [ADDR_WIDTH-1:0] AR,
    output logic [DEPTH_W-1:0]    depth,
    output logic [NUM_WARPS-1:0]  fault
);

    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    // Per-warp architectural state.
    logic [ADDR_WIDTH-1:0] pc    [NUM_WARPS];
    logic [DEPTH_W-1:0]    sp    [NUM_WARPS];
    logic [ADDR_WIDTH-1:0] stack [NUM_WARPS][STACK_DEPTH];
    logic [NUM_WARPS-1:0]  fault_q;

    // Decode of the selected warp and its next state.
    logic                  sel_valid;
    logic [SEL_W-1:0]      sel_idx;
    logic [ADDR_WIDTH-1:0] cur_pc;
    logic [DEPTH_W-1:0]    cur_sp;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [PTR_W-1:0]      top_idx;
    logic [PTR_W-1:0]      push_idx;
    logic [ADDR_WIDTH-1:0] nxt_pc;
    logic [DEPTH_W-1:0]    nxt_sp;
    logic                  upd;
    logic                  push;
    logic                  set_fault;

    // Select the addressed warp and resolve the command with ret > call > load > inc.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        sel_valid = (int'(warp_sel) < NUM_WARPS);
        sel_idx   = sel_valid ? warp_sel : '0;
        cur_pc    = pc[sel_idx];
        cur_sp    = sp[sel_idx];
        pc_inc    = cur_pc + ADDR_WIDTH'(1);
        top_idx   = PTR_W'(cur_sp - DEPTH_W'(1));
        push_idx  = PTR_W'(cur_sp);
        nxt_pc    = cur_pc;
        nxt_sp    = cur_sp;
        upd       = 1'b0;
        push      = 1'b0;
        set_fault = 1'b0;

        if (sel_valid && !fault_q[sel_idx]) begin
            if (ret) begin
                if (cur_sp != '0) begin
                    nxt_pc = stack[sel_idx][top_idx];
                    nxt_sp = cur_sp - DEPTH_W'(1);
                    upd    = 1'b1;
                end else begin
                    set_fault = 1'b1;
                end
            end else if (call) begin
                if (cur_sp != DEPTH_W'(STACK_DEPTH)) begin
                    nxt_pc = I;
                    nxt_sp = cur_sp + DEPTH_W'(1);
                    push   = 1'b1;
                    upd    = 1'b1;
                end else begin
                    set_fault = 1'b1;
                end
            end else if (loadFromI) begin
                nxt_pc = I;
                upd    = 1'b1;
            end else if (incPC) begin
                nxt_pc = pc_inc;
                upd    = 1'b1;
            end
        end
    end

    // PC, stack pointer and fault registers; only the selected warp ever updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc[w] <= RESET_PC;
                sp[w] <= '0;
            end
            fault_q <= '0;
        end else begin
            if (upd) begin
                pc[sel_idx] <= nxt_pc;
                sp[sel_idx] <= nxt_sp;
            end
            if (set_fault) begin
                fault_q[sel_idx] <= 1'b1;
            end
        end
    end

    // Return-address storage; entries above sp are never read.
    always_ff @(posedge clk) begin
        // NOTE: the stack array has no reset; sp = 0 makes its contents unreachable.
        if (push && !reset) begin
            stack[sel_idx][push_idx] <= pc_inc;
        end
    end

    assign AR    = sel_valid ? cur_pc : '0;
    assign depth = sel_valid ? cur_sp : '0;
    assign fault = fault_q;

endmodule
